// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to eight-digit packed BCD converter
module bin2bcd_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] bin_in,
   output logic [31:0]  bcd_out,
   output logic         ovf,
   output logic         busy,
   output logic         valid
);

   // Ten BCD digits sit above the binary field so the full 32-bit range converts exactly.
   localparam int        SW   = W + 40;
   localparam logic [5:0] LAST = 6'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    cap;
   logic [SW-1:0]   sh;
   logic [SW-1:0]   sh_adj;
   logic [5:0]      cnt;
   logic            pend;
   logic            start;

   // A conversion is wanted when the input moved away from the captured copy or one is pending.
   always_comb begin
      start = (bin_in != cap) || pend;
   end

   // Next-state decode; SHIFT leaves after the shift taken while cnt holds its last value.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add 3 to every BCD nibble of 5 or more before the shift; nibbles never carry into each other.
   always_comb begin
      sh_adj = sh;
      for (int i = 0; i < 10; i++) begin
         if (sh[W + 4*i +: 4] >= 4'd5) begin
            sh_adj[W + 4*i +: 4] = sh[W + 4*i +: 4] + 4'd3;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: capture, shift, and publish the result only on the LOAD edge so the display never shows partial values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap     <= '0;
         sh      <= '0;
         cnt     <= '0;
         pend    <= 1'b1;
         bcd_out <= '0;
         ovf     <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  cap  <= bin_in;
                  sh   <= {40'd0, bin_in};
                  cnt  <= '0;
                  pend <= 1'b0;
               end
            end
            SHIFT: begin
               sh  <= {sh_adj[SW-2:0], 1'b0};
               cnt <= cnt + 6'd1;
            end
            LOAD: begin
               bcd_out <= sh[W+31:W];
               ovf     <= |sh[W+39:W+32];
               valid   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;
   logic [31:0] bin_in;
   logic [31:0] bcd_out;
   logic        ovf;
   logic        busy;
   logic        valid;

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   logic        prev_busy = 1'b0;
   logic [31:0] prev_bcd  = '0;

   bin2bcd_seq #(.W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bin_in  (bin_in),
      .bcd_out (bcd_out),
      .ovf     (ovf),
      .busy    (busy),
      .valid   (valid)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_bcd(input logic [31:0] v);
      longint unsigned r;
      logic [31:0]     res;
      r   = longint'(v) % 64'd100000000;
      res = '0;
      for (int d = 0; d < 8; d++) begin
         res[4*d +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return res;
   endfunction

   task automatic push_exp(input logic [31:0] v);
      exp_t e;
      e.bcd = model_bcd(v);
      e.ovf = (v >= 32'd100000000);
      sb.push_back(e);
   endtask

   // Scoreboard: a busy falling edge marks a LOAD; between loads bcd_out must hold still.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && prev_busy && !busy) begin
         if (sb.size() == 0) begin
            check("spurious_load", bcd_out, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("bcd_out", bcd_out, e.bcd);
            check("ovf", 32'(ovf), 32'(e.ovf));
         end
      end else if (rst_n && prev_busy && busy) begin
         check("hold", bcd_out, prev_bcd);
      end
      prev_busy = busy;
      prev_bcd  = bcd_out;
   end

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", sb.size(), 0);
   endtask

   task automatic convert(input logic [31:0] v);
      @(negedge clk);
      bin_in = v;
      push_exp(v);
      repeat (33) @(negedge clk);
      check("lat_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("done_busy", 32'(busy), 32'd0);
      check("done_valid", 32'(valid), 32'd1);
      drain();
   endtask

   initial begin
      logic [31:0] v;
      rst_n  = 1'b0;
      bin_in = 32'd12345;
      push_exp(32'd12345);
      #5;
      check("rst_bcd", bcd_out, 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #15;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("first_busy", 32'(busy), 32'd1);
      repeat (32) @(negedge clk);
      check("pre_valid", 32'(valid), 32'd0);
      check("pre_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_valid", 32'(valid), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_bcd", bcd_out, 32'h0001_2345);
      drain();

      convert(32'h05F5_E0FF);
      convert(32'h05F5_E100);
      convert(32'hFFFF_FFFF);
      convert(32'd0);
      for (int i = 0; i < 6; i++) begin
         v = (i % 2 == 0) ? $urandom : $urandom_range(99999999, 0);
         if (v == bin_in) v = v ^ 32'd1;
         convert(v);
      end

      // Input changes mid-conversion: 42 completes first, then 7 back-to-back.
      @(negedge clk);
      bin_in = 32'd42;
      push_exp(32'd42);
      repeat (10) @(negedge clk);
      bin_in = 32'd7;
      push_exp(32'd7);
      repeat (23) @(negedge clk);
      check("chg_busy33", 32'(busy), 32'd1);
      @(negedge clk);
      check("chg_bcd42", bcd_out, 32'h0000_0042);
      check("chg_busy34", 32'(busy), 32'd0);
      @(negedge clk);
      check("chg_cap7", 32'(busy), 32'd1);
      repeat (33) @(negedge clk);
      check("chg_bcd7", bcd_out, 32'h0000_0007);
      check("chg_idle", 32'(busy), 32'd0);
      drain();

      // Reset in the middle of a conversion discards it; the value is reconverted afterwards.
      @(negedge clk);
      bin_in = 32'h1234_5678;
      push_exp(32'h1234_5678);
      repeat (15) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_bcd", bcd_out, 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (33) @(negedge clk);
      check("rr_valid_pre", 32'(valid), 32'd0);
      check("rr_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("rr_valid", 32'(valid), 32'd1);
      check("rr_bcd", bcd_out, 32'h0541_9896);
      check("rr_ovf", 32'(ovf), 32'd1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter between the CPU's 32-bit display output port (`io2_out`) and the eight `hexdriver` digit decoders. It watches the 32-bit value, runs a 32-cycle shift-and-add-3 (double-dabble) conversion whenever the value changes, and holds the last eight decimal digits as packed BCD, so the seven-segment bank shows decimal instead of hex. Digit `n` of `bcd_out`, bits `[4n+3:4n]`, feeds the decoder for HEXn.

## Interface
- `W`, default 32: width of the binary input. The shift counter runs to `W`.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `bin_in`  in  32: unsigned binary value from the CPU output port.
- `bcd_out`  out  32: eight packed BCD digits. `[3:0]` is the units digit.
- `ovf`  out  1: high when the converted value is ≥ 100,000,000, so the upper two decimal digits are dropped.
- `busy`  out  1: high while a conversion is in progress.
- `valid`  out  1: high once at least one conversion has completed since reset.

## Operation
- Internal registers:
  - `cap`: 32-bit captured input.
  - `sh`: 72-bit working register, made of 40 bits of BCD (10 digits) above 32 bits of binary.
  - `cnt`: 6-bit shift counter.
  - `pend`: flag requesting a conversion.
  - `state`: one of IDLE, SHIFT, LOAD.
- IDLE:
  - Start a conversion if `bin_in != cap` or `pend == 1`.
  - On start: `cap <= bin_in`, `sh <= {40'd0, bin_in}`, `cnt <= 0`, `pend <= 0`, go to SHIFT.
- SHIFT, one iteration per cycle:
  - First, every BCD nibble ≥ 5 of `sh[71:32]` gets +3 (4-bit add, no carry between nibbles).
  - Then the whole 72-bit `sh` shifts left by 1.
  - `cnt <= cnt + 1`.
  - When `cnt == W-1`, the current shift is the last one: go to LOAD.
- LOAD:
  - `bcd_out <= sh[63:32]`.
  - `ovf <= |sh[71:64]`.
  - `valid <= 1`.
  - Go to IDLE.
- Changes on `bin_in` during SHIFT or LOAD are ignored. On return to IDLE, the comparison against `cap` picks up any difference on the next cycle. The final settled value is always converted.
- `busy` is registered: 1 in SHIFT and LOAD, 0 in IDLE.
- Double-dabble invariant: no BCD nibble of `sh` exceeds 9 after any shift. The result is exact for every 32-bit input, up to 4,294,967,295 (10 digits).

## Timing
- Reset (async assert, sync use after deassert):
  - `bcd_out = 0`, `ovf = 0`, `valid = 0`, `busy = 0`.
  - `cap = 0`, `sh = 0`, `cnt = 0`, `state = IDLE`, `pend = 1`.
  - Because `pend = 1`, the first edge after reset deassertion starts a conversion even when `bin_in == 0`.
- Latency, counting edge E0 as the IDLE edge that captures the value:
  - Shifts happen on E1..E32.
  - `bcd_out`, `ovf` and `valid` update on E33.
  - `busy` goes high after E0 and low after E33.
  - Capture to output is 33 cycles; a conversion occupies 34 cycles including the capture cycle.
- Back-to-back: if `bin_in` differs from `cap` at E34 (the first IDLE edge), the next conversion captures on E34.
- `bcd_out` and `ovf` change only on the LOAD edge, never mid-conversion. The display does not flicker through partial results.
- Reset asserted mid-conversion:
  - Immediate return to reset values; the partial result is discarded and `valid` drops to 0.
  - After deassertion, the current `bin_in` is reconverted (`pend`).
- Width rules:
  - `cnt` must reach 31 without overflow.
  - The add-3 is applied per nibble before the shift, never after.
  - `ovf` reflects digits 9..8 only.

## Test plan
- Reset with `bin_in = 12345` held, deassert at t = 20 ns:
  - `busy` rises after the first edge.
  - 33 cycles later, `bcd_out = 0x00012345`, `ovf = 0`, `valid = 1`.
- `bin_in = 99,999,999` (0x05F5E0FF) → `bcd_out = 0x99999999`, `ovf = 0`.
- `bin_in = 100,000,000` (0x05F5E100) → `bcd_out = 0x00000000`, `ovf = 1`.
- `bin_in = 0xFFFFFFFF` → `bcd_out = 0x94967295`, `ovf = 1`.
- Change `bin_in` from 42 to 7 ten cycles into the conversion of 42:
  - `bcd_out = 0x00000042` at E33; `busy` stays high only through LOAD.
  - The conversion of 7 captures at E34; `bcd_out = 0x00000007` at E67.
  - No other intermediate `bcd_out` values appear.
- Assert `rst_n` at cycle 15 of a conversion of 0x12345678:
  - Outputs go to 0 and `valid = 0` immediately, asynchronously.
  - After release, `bcd_out = 0x05419896`, `ovf = 1` (305,419,896) 33 cycles after the first post-reset edge.
